// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data memory behind a three-state request FSM
// (IDLE -> ACCESS -> RESP -> IDLE).
//
// Ports
//   clk_dm       in   sole clock, rising edge
//   rst          in   synchronous active-high reset (memory array is not cleared)
//   req          in   request valid; accepted only while ready=1
//   Mem_Write    in   1 = store, 0 = load
//   Mem_Size     in   00 byte, 01 half, 10 word, 11 reserved (faults)
//   Mem_Unsigned in   1 = zero-extend loads, 0 = sign-extend
//   DM_Addr      in   byte address [ADDR_W-1:0]
//   M_W_Data     in   right-aligned store data
//   ready        out  high in IDLE
//   done         out  high for the single RESP cycle
//   err          out  high with done when the request faulted
//   M_R_Data     out  extended load result, held until the next successful load
module data_mem_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter bit          LITTLE_END = 1'b1
) (
    input  logic              clk_dm,
    input  logic              rst,
    input  logic              req,
    input  logic              Mem_Write,
    input  logic [1:0]        Mem_Size,
    input  logic              Mem_Unsigned,
    input  logic [ADDR_W-1:0] DM_Addr,
    input  logic [31:0]       M_W_Data,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       M_R_Data
);

    localparam int unsigned Depth = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                wr_q, uns_q, err_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q, rdata_q;
    logic [31:0]         mem_q [Depth];

    logic [ADDR_W-3:0]   idx;
    logic [1:0]          off;
    logic                fault;
    logic [4:0]          sh;
    logic [31:0]         cur_word, shifted, load_val, mask, merged;

    assign idx      = addr_q[ADDR_W-1:2];
    assign off      = addr_q[1:0];
    assign cur_word = mem_q[idx];

    always_comb begin
        fault = (size_q == 2'b11) || (size_q == 2'b01 && off[0]) ||
                (size_q == 2'b10 && off != 2'b00);
        // Bit position of the addressed lane(s); big-endian mirrors the byte offset.
        unique case (size_q)
            2'b00:   sh = LITTLE_END ? {off, 3'b000} : {~off, 3'b000};
            2'b01:   sh = LITTLE_END ? {off[1], 4'b0000} : {~off[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        shifted = cur_word >> sh;
        unique case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                mask     = 32'h0000_00FF << sh;
            end
            2'b01: begin
                load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                mask     = 32'h0000_FFFF << sh;
            end
            default: begin
                load_val = cur_word;
                mask     = 32'hFFFF_FFFF;
            end
        endcase
        merged = (cur_word & ~mask) | ((wdata_q << sh) & mask);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StResp);
    assign err      = done && err_q;
    assign M_R_Data = rdata_q;

    always_ff @(posedge clk_dm) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                wr_q    <= Mem_Write;
                uns_q   <= Mem_Unsigned;
                size_q  <= Mem_Size;
                addr_q  <= DM_Addr;
                wdata_q <= M_W_Data;
            end
            if (state_q == StAccess) begin
                err_q <= fault;
                if (!fault && !wr_q) rdata_q <= load_val;
            end
        end
    end

    // Array has no reset; a reset at the ACCESS edge drops the pending store.
    always_ff @(posedge clk_dm) begin
        if (!rst && state_q == StAccess && wr_q && !fault) mem_q[idx] <= merged;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, wr, un;
    logic [1:0]    sz;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          rdy_le, done_le, err_le, rdy_be, done_be, err_be;
    logic [31:0]   rd_le, rd_be;

    data_mem_ctrl #(.ADDR_W(AW), .LITTLE_END(1'b1)) dut_le (
        .clk_dm(clk), .rst(rst), .req(req), .Mem_Write(wr), .Mem_Size(sz),
        .Mem_Unsigned(un), .DM_Addr(addr), .M_W_Data(wd),
        .ready(rdy_le), .done(done_le), .err(err_le), .M_R_Data(rd_le)
    );

    data_mem_ctrl #(.ADDR_W(AW), .LITTLE_END(1'b0)) dut_be (
        .clk_dm(clk), .rst(rst), .req(req), .Mem_Write(wr), .Mem_Size(sz),
        .Mem_Unsigned(un), .DM_Addr(addr), .M_W_Data(wd),
        .ready(rdy_be), .done(done_be), .err(err_be), .M_R_Data(rd_be)
    );

    int errors = 0;
    int checks = 0;

    // Byte-addressed reference memories, one per byte order.
    logic [7:0]  mem_le [1024];
    logic [7:0]  mem_be [1024];
    logic [31:0] exp_le, exp_be;

    logic        o_done_be, o_err_le, o_err_be;
    logic [31:0] o_rd_le, o_rd_be;

    typedef struct {
        bit          w;
        logic [1:0]  s;
        bit          u;
        logic [9:0]  a;
        logic [31:0] d;
    } op_t;

    function automatic op_t mk(bit w, logic [1:0] s, bit u, logic [9:0] a, logic [31:0] d);
        op_t o;
        o.w = w; o.s = s; o.u = u; o.a = a; o.d = d;
        return o;
    endfunction

    function automatic bit m_fault(logic [1:0] s, int a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    // Byte k of the access holds value significance k (LE) or n-1-k (BE).
    function automatic logic [31:0] m_load(bit be, logic [1:0] s, bit u, int a);
        int n;
        logic [31:0] v;
        logic [7:0]  b;
        n = 1 << s;
        v = '0;
        for (int k = 0; k < n; k++) begin
            b = be ? mem_be[a+k] : mem_le[a+k];
            if (be) v[8*(n-1-k) +: 8] = b;
            else    v[8*k +: 8] = b;
        end
        if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic m_apply(op_t o);
        int n;
        n = 1 << o.s;
        if (m_fault(o.s, o.a)) return;
        if (o.w) begin
            for (int k = 0; k < n; k++) begin
                mem_le[o.a+k] = o.d[8*k +: 8];
                mem_be[o.a+k] = o.d[8*(n-1-k) +: 8];
            end
        end else begin
            exp_le = m_load(1'b0, o.s, o.u, o.a);
            exp_be = m_load(1'b1, o.s, o.u, o.a);
        end
    endtask

    // Issue one request, report latency (edges from acceptance to done) and whether
    // done was a single-cycle pulse followed by ready.
    task automatic txn(input op_t o, output int lat, output bit pw_ok);
        int n;
        @(negedge clk);
        n = 0;
        while (!(rdy_le && rdy_be) && n < 8) begin
            @(negedge clk);
            n++;
        end
        req = 1'b1; wr = o.w; sz = o.s; un = o.u; addr = o.a; wd = o.d;
        @(negedge clk);
        // Scramble inputs: the accepted request must already be captured.
        req = 1'b0; wr = 1'($urandom); sz = 2'($urandom); un = 1'($urandom);
        addr = AW'($urandom); wd = $urandom;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            if (done_le) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        o_done_be = done_be; o_err_le = err_le; o_err_be = err_be;
        o_rd_le = rd_le; o_rd_be = rd_be;
        @(negedge clk);
        pw_ok = !done_le && !done_be && rdy_le && rdy_be;
    endtask

    function automatic logic [71:0] obs_vec(int lat, bit pw);
        logic [3:0] l;
        l = lat[3:0];
        return {l, pw, o_done_be, o_err_le, o_err_be, o_rd_le, o_rd_be};
    endfunction

    function automatic logic [71:0] exp_vec(op_t o);
        bit f;
        f = m_fault(o.s, o.a);
        return {4'd2, 1'b1, 1'b1, f, f, exp_le, exp_be};
    endfunction

    task automatic test_reset();
        req = 1'b0; wr = 1'b0; sz = 2'b00; un = 1'b0; addr = '0; wd = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdy_le, done_le, err_le, rd_le, rdy_be, done_be, err_be, rd_be} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: rdy/done/err/rd le=%b%b%b %h be=%b%b%b %h want 100 0",
                     rdy_le, done_le, err_le, rd_le, rdy_be, done_be, err_be, rd_be);
        end
        rst = 1'b0;
        exp_le = 32'h0; exp_be = 32'h0;
    endtask

    task automatic init_mem();
        int lat;
        bit pw;
        op_t o;
        for (int i = 0; i < 256; i++) begin
            o = mk(1'b1, 2'b10, 1'b0, 10'(i*4), $urandom);
            txn(o, lat, pw);
            m_apply(o);
        end
    endtask

    task automatic test_word();
        op_t ops [2];
        int lat;
        bit pw;
        ops[0] = mk(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
        ops[1] = mk(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        foreach (ops[i]) begin
            txn(ops[i], lat, pw);
            m_apply(ops[i]);
            checks++;
            if (obs_vec(lat, pw) !== exp_vec(ops[i])) begin
                errors++;
                $display("FAIL word op%0d: got %h want %h", i, obs_vec(lat, pw), exp_vec(ops[i]));
            end
        end
        checks++;
        if (o_rd_le !== 32'hDEADBEEF || o_rd_be !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_value: le=%h be=%h want deadbeef", o_rd_le, o_rd_be);
        end
    endtask

    task automatic test_byte_lanes();
        op_t ops [5];
        logic [31:0] lit_le [5];
        logic [31:0] lit_be [5];
        int lat;
        bit pw;
        ops[0] = mk(1'b1, 2'b10, 1'b0, 10'h010, 32'h0);
        ops[1] = mk(1'b1, 2'b00, 1'b0, 10'h011, 32'hABCD_EF80);
        ops[2] = mk(1'b0, 2'b00, 1'b0, 10'h011, 32'h0);
        ops[3] = mk(1'b0, 2'b00, 1'b1, 10'h011, 32'h0);
        ops[4] = mk(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        lit_le[2] = 32'hFFFFFF80; lit_le[3] = 32'h00000080; lit_le[4] = 32'h00008000;
        lit_be[2] = 32'hFFFFFF80; lit_be[3] = 32'h00000080; lit_be[4] = 32'h00800000;
        foreach (ops[i]) begin
            txn(ops[i], lat, pw);
            m_apply(ops[i]);
            checks++;
            if (obs_vec(lat, pw) !== exp_vec(ops[i])) begin
                errors++;
                $display("FAIL lanes op%0d: got %h want %h", i, obs_vec(lat, pw), exp_vec(ops[i]));
            end
            if (i >= 2) begin
                checks++;
                if (o_rd_le !== lit_le[i] || o_rd_be !== lit_be[i]) begin
                    errors++;
                    $display("FAIL lanes_lit op%0d: le=%h be=%h want %h %h",
                             i, o_rd_le, o_rd_be, lit_le[i], lit_be[i]);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        op_t ops [7];
        int lat;
        bit pw;
        ops[0] = mk(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        ops[1] = mk(1'b0, 2'b01, 1'b0, 10'h013, 32'h0);
        ops[2] = mk(1'b0, 2'b10, 1'b0, 10'h012, 32'h0);
        ops[3] = mk(1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
        ops[4] = mk(1'b1, 2'b01, 1'b0, 10'h013, 32'h0000_FFFF);
        ops[5] = mk(1'b1, 2'b10, 1'b0, 10'h011, 32'h5555_5555);
        ops[6] = mk(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        foreach (ops[i]) begin
            txn(ops[i], lat, pw);
            m_apply(ops[i]);
            checks++;
            if (obs_vec(lat, pw) !== exp_vec(ops[i])) begin
                errors++;
                $display("FAIL misalign op%0d: got %h want %h", i, obs_vec(lat, pw), exp_vec(ops[i]));
            end
        end
        checks++;
        if (o_rd_le !== 32'h00008000) begin
            errors++;
            $display("FAIL misalign_unchanged: le=%h want 00008000", o_rd_le);
        end
    endtask

    task automatic test_back_to_back();
        int ph;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; sz = 2'b10; un = 1'b0; addr = 10'h014; wd = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            ph = (i - 1) % 3;
            checks++;
            if ({rdy_le, done_le, rdy_be, done_be} !== {2{ph == 2, ph == 1}}) begin
                errors++;
                $display("FAIL b2b cyc%0d: rdy/done le=%b%b be=%b%b want %b%b",
                         i, rdy_le, done_le, rdy_be, done_be, ph == 2, ph == 1);
            end
        end
        req = 1'b0;
        m_apply(mk(1'b0, 2'b10, 1'b0, 10'h014, 32'h0));
        checks++;
        if (rd_le !== exp_le || rd_be !== exp_be) begin
            errors++;
            $display("FAIL b2b_data: le=%h be=%h want %h %h", rd_le, rd_be, exp_le, exp_be);
        end
    endtask

    task automatic test_reset_in_access();
        op_t o;
        int lat;
        bit pw;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; sz = 2'b10; un = 1'b0; addr = 10'h020; wd = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_le = 32'h0; exp_be = 32'h0;
        checks++;
        if ({rdy_le, done_le, err_le, rd_le, rdy_be, done_be} !== {3'b100, 32'h0, 2'b10}) begin
            errors++;
            $display("FAIL rst_access: rdy/done/err=%b%b%b rd=%h be=%b%b want 100 0 10",
                     rdy_le, done_le, err_le, rd_le, rdy_be, done_be);
        end
        @(negedge clk);
        checks++;
        if (done_le !== 1'b0 || done_be !== 1'b0) begin
            errors++;
            $display("FAIL rst_nodone: done le=%b be=%b want 0", done_le, done_be);
        end
        o = mk(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
        txn(o, lat, pw);
        m_apply(o);
        checks++;
        if (obs_vec(lat, pw) !== exp_vec(o)) begin
            errors++;
            $display("FAIL rst_prior: got %h want %h", obs_vec(lat, pw), exp_vec(o));
        end
    endtask

    task automatic test_high_addr();
        op_t ops [3];
        int lat;
        bit pw;
        ops[0] = mk(1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFE_F00D);
        ops[1] = mk(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0);
        ops[2] = mk(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
        foreach (ops[i]) begin
            txn(ops[i], lat, pw);
            m_apply(ops[i]);
            checks++;
            if (obs_vec(lat, pw) !== exp_vec(ops[i])) begin
                errors++;
                $display("FAIL high op%0d: got %h want %h", i, obs_vec(lat, pw), exp_vec(ops[i]));
            end
            if (i == 1) begin
                checks++;
                if (o_rd_le !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL high_value: le=%h want cafef00d", o_rd_le);
                end
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        int lat;
        bit pw;
        logic [9:0] a;
        for (int i = 0; i < 150; i++) begin
            a = 10'($urandom);
            o = mk(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 9) < 7) begin
                if (o.s == 2'b01) o.a[0] = 1'b0;
                if (o.s[1]) o.a[1:0] = 2'b00;
            end
            txn(o, lat, pw);
            m_apply(o);
            checks++;
            if (obs_vec(lat, pw) !== exp_vec(o)) begin
                errors++;
                $display("FAIL random%0d w=%b s=%b u=%b a=%h: got %h want %h",
                         i, o.w, o.s, o.u, o.a, obs_vec(lat, pw), exp_vec(o));
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_word();
        test_byte_lanes();
        test_misaligned();
        test_back_to_back();
        test_reset_in_access();
        test_high_addr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
